imem_loader: RTL and testbench

- Boot-time writer for the instruction memory's write port (we/a/wd).
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Checks a trailing additive checksum and holds the core in reset until a load completes successfully.
- Sits between the host/UART byte source and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_byte_assembler.sv | 34 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Little-endian placement: lane 0 carries bits 7:0.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port seen by the loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_a, mem_wd
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/imem_byte_assembler.sv
// Collects four accepted bytes into a little-endian word; shared by all stream fields.
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_reg;
  logic [31:0] data_reg;

  // The completed word is visible in the same cycle as its last byte.
  assign word       = place_byte(data_reg, lane_reg, byte_data);
  assign word_valid = byte_valid && (lane_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg <= 2'd0;
      data_reg <= 32'd0;
    end else if (clr) begin
      lane_reg <= 2'd0;
      data_reg <= 32'd0;
    end else if (byte_valid) begin
      lane_reg <= lane_reg + 2'd1;
      data_reg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: LEN | DATA words | CSUM byte stream into instruction memory, core held until success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          SIZE      = 32768,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  imem_loader_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  core_hold,
  output logic [$clog2(SIZE):0] word_count
);

  localparam int CW = $clog2(SIZE) + 1;

  state_t         state_reg, state_next;
  logic [31:0]    len_reg;
  logic [31:0]    sum_reg;
  logic [CW-1:0]  count_reg;
  logic [CW-1:0]  count_inc;
  logic [31:0]    mem_a_reg;
  logic [31:0]    mem_wd_reg;
  logic           in_ready;
  logic           mem_we;
  logic           accept_start;
  logic           asm_valid;
  logic [31:0]    asm_word;

  assign count_inc = count_reg + 1'b1;

  imem_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept_start),
    .byte_valid (bus.in_valid && in_ready),
    .byte_data  (bus.in_data),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  always_comb begin
    state_next   = state_reg;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    core_hold    = 1'b1;
    accept_start = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept_start = 1'b1;
          state_next   = LEN;
        end
      end
      LEN: begin
        in_ready = 1'b1;
        if (asm_valid) begin
          if (asm_word == 32'd0)            state_next = CSUM;
          else if (asm_word > 32'(SIZE))    state_next = ERR;
          else                              state_next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (asm_valid) state_next = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (32'(count_inc) == len_reg) state_next = CSUM;
        else                           state_next = DATA;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (asm_valid) state_next = (asm_word == sum_reg) ? DONE : ERR;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) begin
          accept_start = 1'b1;
          state_next   = LEN;
        end
      end
      ERR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (start) begin
          accept_start = 1'b1;
          state_next   = LEN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      len_reg    <= 32'd0;
      sum_reg    <= 32'd0;
      count_reg  <= '0;
      mem_a_reg  <= BASE_ADDR;
      mem_wd_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept_start) begin
        sum_reg   <= 32'd0;
        count_reg <= '0;
      end
      if (state_reg == LEN && asm_valid) len_reg <= asm_word;
      // Address and data are captured one cycle early so WRITE presents them registered.
      if (state_reg == DATA && asm_valid) begin
        mem_wd_reg <= asm_word;
        mem_a_reg  <= BASE_ADDR + 32'({count_reg, 2'b00});
      end
      if (state_reg == WRITE) begin
        sum_reg   <= sum_reg + mem_wd_reg;
        count_reg <= count_inc;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.mem_we   = mem_we;
  assign bus.mem_a    = mem_a_reg;
  assign bus.mem_wd   = mem_wd_reg;
  assign word_count   = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load streams checked against a stream-level write/outcome model.
module tb_imem_loader;

  localparam int          SIZE = 8;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          CW   = $clog2(SIZE) + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err, core_hold;
  logic [CW-1:0] word_count;

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  wr_t           exp_q[$];
  logic [31:0]   data_w[0:15];

  imem_loader_if bus ();

  imem_loader #(.SIZE(SIZE), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_hold  (core_hold),
    .word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every write must match the oldest expected write, one cycle after its last data byte.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      wr_t e;
      chk("in_ready_during_write", {31'b0, bus.in_ready}, 32'd0);
      chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", bus.mem_a, e.a);
        chk("write_data", bus.mem_wd, e.d);
        chk("write_cycle", 32'(cyc), 32'(e.c));
        $display("write a=%08h wd=%08h cycle=%0d", bus.mem_a, bus.mem_wd, cyc);
      end
    end
  end

  task automatic check_reset_values(input string when);
    $display("reset-value check (%s)", when);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_a", bus.mem_a, BASE);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
    chk("rst_word_count", 32'(word_count), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends the low nbytes of w, LSB first; optional random gaps before each byte.
  task automatic send_bytes(input logic [31:0] w, input int nbytes, input int gapmax,
                            input bit poke, input bit is_data, input logic [31:0] wa);
    int gap;
    int waited;
    for (int k = 0; k < nbytes; k++) begin
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w[8*k +: 8];
      start        = poke && (k == 0);
      waited       = 0;
      while (bus.in_ready !== 1'b1 && waited < 40) begin
        @(negedge clk);
        start = 1'b0;
        waited++;
      end
      if (bus.in_ready !== 1'b1) chk("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
      if (is_data && k == 3) exp_q.push_back('{wa, w, cyc + 1});
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (busy === 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("load_finished", {31'b0, busy}, 32'd0);
  endtask

  // Model: writes go to BASE+4*i in order; success iff N fits and CSUM equals the 32-bit sum.
  task automatic run_load(input string name, input bit do_start, input logic [31:0] n,
                          input logic [31:0] csum, input int gapmax, input int poke_word);
    logic [31:0] sum = 32'd0;
    bit          ok;
    if (do_start) pulse_start();
    send_bytes(n, 4, gapmax, 1'b0, 1'b0, 32'd0);
    if (n > SIZE) begin
      chk("oversize_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("oversize_err", {31'b0, err}, 32'd1);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        send_bytes(data_w[i], 4, gapmax, (i == poke_word), 1'b1, BASE + 32'(4 * i));
        sum = sum + data_w[i];
      end
      send_bytes(csum, 4, gapmax, 1'b0, 1'b0, 32'd0);
      ok = (csum == sum);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("done", {31'b0, done}, {31'b0, ok});
    chk("err", {31'b0, err}, {31'b0, !ok});
    chk("core_hold", {31'b0, core_hold}, {31'b0, !ok});
    chk("word_count", 32'(word_count), (n > SIZE) ? 32'd0 : n);
    $display("load %s: N=%0d ok=%0d done=%0b err=%0b word_count=%0d",
             name, n, ok, done, err, word_count);
  endtask

  function automatic logic [31:0] sum_words(input int n);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < n; i++) s = s + data_w[i];
    return s;
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_values("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after release");

    data_w[0] = 32'h0000_0013;
    data_w[1] = 32'h0010_0093;
    run_load("two_words", 1'b1, 32'd2, 32'h0010_00A6, 0, -1);

    run_load("empty_ok", 1'b1, 32'd0, 32'd0, 0, -1);
    run_load("empty_bad", 1'b1, 32'd0, 32'd1, 0, -1);
    run_load("oversize", 1'b1, 32'(SIZE + 1), 32'd0, 0, -1);

    for (int i = 0; i < 3; i++) data_w[i] = $urandom;
    run_load("gappy_three", 1'b1, 32'd3, sum_words(3), 10, -1);

    for (int i = 0; i < SIZE; i++) data_w[i] = $urandom;
    run_load("full_size", 1'b1, 32'(SIZE), sum_words(SIZE), 2, -1);

    for (int i = 0; i < 2; i++) data_w[i] = $urandom;
    run_load("bad_csum", 1'b1, 32'd2, sum_words(2) + 32'd1, 1, -1);

    for (int i = 0; i < 3; i++) data_w[i] = $urandom;
    run_load("start_mid_data", 1'b1, 32'd3, sum_words(3), 0, 1);

    pulse_start();
    chk("restart_busy", {31'b0, busy}, 32'd1);
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_core_hold", {31'b0, core_hold}, 32'd1);
    chk("restart_word_count", 32'(word_count), 32'd0);
    data_w[0] = $urandom;
    run_load("after_restart", 1'b0, 32'd1, sum_words(1), 0, -1);

    // Abort after 6 data bytes: word 0 is written, word 1 is only half assembled.
    data_w[0] = $urandom;
    data_w[1] = $urandom;
    pulse_start();
    send_bytes(32'd2, 4, 0, 1'b0, 1'b0, 32'd0);
    send_bytes(data_w[0], 4, 0, 1'b0, 1'b1, BASE);
    send_bytes(data_w[1], 2, 0, 1'b0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async mid-load");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_writes_outstanding", 32'(exp_q.size()), 32'd0);
    data_w[0] = $urandom;
    run_load("after_abort", 1'b1, 32'd1, sum_words(1), 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
